// File: rtl/speed_controller.sv
// Speed controller for the scrolling pattern generators.
// Produces a 3-bit fixed-point step size (bit2 = 2 px/frame, bits[1:0] =
// quarter-step fractions). Speed comes from two debounced push-buttons with
// auto-repeat, or from an automatic triangle sweep; pause forces zero motion.
// All state except the input synchronizers advances only on next_frame.
module speed_controller #(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 16,
    parameter int RAMP_FRAMES     = 32,
    parameter int DEFAULT_LEVEL   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       next_frame,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       mode_auto,
    input  logic       pause,
    output logic [2:0] step_size,
    output logic [2:0] speed_level,
    output logic       ramp_dir
);

    localparam logic [2:0] L_DEFAULT = 3'(DEFAULT_LEVEL);
    localparam logic [3:0] L_DEB_N   = 4'(DEBOUNCE_FRAMES);
    localparam logic [5:0] L_REP_N   = 6'(REPEAT_FRAMES);
    localparam logic [5:0] L_RAMP_N  = 6'(RAMP_FRAMES);
    localparam logic [2:0] L_MAX     = 3'd7;

    // Synchronized inputs, bit order {pause, mode_auto, btn_down, btn_up}
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;

    // Per-button state, index 0 = up, 1 = down
    logic [1:0]      r_deb;
    logic [1:0][3:0] r_deb_cnt;
    logic [1:0][5:0] r_hold_cnt;

    logic            r_lock;
    logic            r_auto_prev;
    logic [5:0]      r_ramp_cnt;

    logic [1:0]      w_deb_next;
    logic [1:0][3:0] w_deb_cnt_next;
    logic [1:0][5:0] w_hold_next;
    logic [1:0]      w_press;
    logic [1:0]      w_rep;
    logic [1:0]      w_evt;

    logic            w_auto;
    logic            w_pause;
    logic [2:0]      w_level_next;
    logic            w_dir_next;
    logic            w_lock_next;
    logic [5:0]      w_ramp_next;

    assign w_auto  = r_sync2[2];
    assign w_pause = r_sync2[3];

    // Two-flop synchronizer chain for every asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
        end else begin
            r_sync1 <= {pause, mode_auto, btn_down, btn_up};
            r_sync2 <= r_sync1;
        end
    end

    // Debounce and press/auto-repeat detection for both buttons
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_deb_next[i]     = r_deb[i];
            w_deb_cnt_next[i] = 4'd0;
            if (r_sync2[i] != r_deb[i]) begin
                if (r_deb_cnt[i] + 4'd1 == L_DEB_N) begin
                    w_deb_next[i] = r_sync2[i];
                end else begin
                    w_deb_cnt_next[i] = r_deb_cnt[i] + 4'd1;
                end
            end
            // A press is the debounced level rising on this frame edge
            w_press[i] = ~r_deb[i] & w_deb_next[i];
            w_rep[i]   = r_deb[i] & (r_hold_cnt[i] + 6'd1 == L_REP_N);
            w_evt[i]   = w_press[i] | w_rep[i];
            // Hold count restarts on release, on press (deb was 0) and on each repeat
            w_hold_next[i] = (!r_deb[i] || w_rep[i]) ? 6'd0 : r_hold_cnt[i] + 6'd1;
        end
    end

    // Next level, sweep direction, lockout and ramp counter
    always_comb begin
        w_level_next = speed_level;
        w_dir_next   = ramp_dir;
        w_lock_next  = r_lock;
        w_ramp_next  = r_ramp_cnt;

        // Lockout persists until both buttons are released, in either mode
        if (r_lock) begin
            if (w_deb_next == 2'b00) begin
                w_lock_next = 1'b0;
            end
        end else if (!w_auto && w_deb_next == 2'b11) begin
            w_lock_next = 1'b1;
        end

        if (!w_auto) begin
            if (!r_lock) begin
                if (w_deb_next == 2'b11) begin
                    w_level_next = L_DEFAULT;
                end else if (w_evt == 2'b01) begin
                    if (speed_level != L_MAX) w_level_next = speed_level + 3'd1;
                end else if (w_evt == 2'b10) begin
                    if (speed_level != 3'd0) w_level_next = speed_level - 3'd1;
                end
            end
        end else if (!r_auto_prev) begin
            // Entering auto restarts the sweep upward from the current level
            w_ramp_next = 6'd0;
            w_dir_next  = 1'b0;
        end else if (r_ramp_cnt + 6'd1 == L_RAMP_N) begin
            w_ramp_next = 6'd0;
            if (!ramp_dir) begin
                if (speed_level == L_MAX) begin
                    w_dir_next   = 1'b1;
                    w_level_next = 3'd6;
                end else begin
                    w_level_next = speed_level + 3'd1;
                end
            end else begin
                if (speed_level == 3'd0) begin
                    w_dir_next   = 1'b0;
                    w_level_next = 3'd1;
                end else begin
                    w_level_next = speed_level - 3'd1;
                end
            end
        end else begin
            w_ramp_next = r_ramp_cnt + 6'd1;
        end
    end

    // Frame-rate state update and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb       <= 2'b00;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_lock      <= 1'b0;
            r_auto_prev <= 1'b0;
            r_ramp_cnt  <= 6'd0;
            speed_level <= L_DEFAULT;
            step_size   <= L_DEFAULT;
            ramp_dir    <= 1'b0;
        end else if (next_frame) begin
            r_deb       <= w_deb_next;
            r_deb_cnt   <= w_deb_cnt_next;
            r_hold_cnt  <= w_hold_next;
            r_lock      <= w_lock_next;
            r_auto_prev <= w_auto;
            r_ramp_cnt  <= w_ramp_next;
            speed_level <= w_level_next;
            step_size   <= w_pause ? 3'd0 : w_level_next;
            ramp_dir    <= w_dir_next;
        end
    end

endmodule
